regfile_sb: RTL and testbench

- Parametrised successor to the team's 8x16 register file: configurable width/depth, 2 async read ports, 1 sync write port.
- Adds a per-register pending scoreboard for load-use stall detection and a sequential soft-clear sweep.
- Sits in the decode stage of the MIPS datapath; hazard unit consumes rd_ready1/rd_ready2.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the regfile_sb register file.
// Optional write-through forwarding in the top is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 3;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for load-use detection, with set, write-clear and sweep-clear paths
// plus two combinational pending lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned AddrW = DefAddrW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic [AddrW-1:0] set_addr_i,
  input  logic             clr_i,
  input  logic [AddrW-1:0] clr_addr_i,
  input  logic             sweep_i,
  input  logic [AddrW-1:0] sweep_addr_i,
  input  logic [AddrW-1:0] rd_addr1_i,
  input  logic [AddrW-1:0] rd_addr2_i,
  output logic             pend1_o,
  output logic             pend2_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Depth-1:0] pend_d, pend_q;

  always_comb begin
    pend_d = pend_q;
    if (sweep_i) begin
      pend_d[sweep_addr_i] = 1'b0;
    end else begin
      if (clr_i) pend_d[clr_addr_i] = 1'b0;
      // Set is applied last so a same-address load issue wins over the retiring write.
      if (set_i) pend_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend1_o = pend_q[rd_addr1_i];
  assign pend2_o = pend_q[rd_addr2_i];

endmodule

// File: rtl/regfile_sb.sv
// Parametrised 2R/1W register file with pending scoreboard and sequential soft-clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_ready1,
  output logic              rd_ready2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              clr_req,
  output logic              busy
);

  localparam int unsigned       Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(Depth - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [Depth];
  logic              wr_go;
  logic              pend1, pend2;

  assign wr_go = wr_en && !busy_q;
  assign busy  = busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          // Counter wraps to 0 on the same edge that returns to idle.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (busy_q) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_go) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .AddrW (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .set_i        (pend_set && !busy_q),
    .set_addr_i   (pend_addr),
    .clr_i        (wr_go),
    .clr_addr_i   (wr_addr),
    .sweep_i      (busy_q),
    .sweep_addr_i (cnt_q),
    .rd_addr1_i   (rd_addr1),
    .rd_addr2_i   (rd_addr2),
    .pend1_o      (pend1),
    .pend2_o      (pend2)
  );

  always_comb begin
    rd_data1  = mem_q[rd_addr1];
    rd_data2  = mem_q[rd_addr2];
    rd_ready1 = !pend1 && !busy_q;
    rd_ready2 = !pend2 && !busy_q;
`ifdef REGFILE_BYPASS_EN
    if (wr_go && (wr_addr == rd_addr1)) begin
      rd_data1  = wr_data;
      rd_ready1 = 1'b1;
    end
    if (wr_go && (wr_addr == rd_addr2)) begin
      rd_data2  = wr_data;
      rd_ready2 = 1'b1;
    end
`else
    // Reads see stored contents only; writes appear after the edge.
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed steps then random traffic against an array model.
module tb_regfile_sb;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_ready1, rd_ready2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          pend_set;
  logic [AW-1:0] pend_addr;
  logic          clr_req;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays plus a remaining-sweep-cycles count.
  logic [DW-1:0] mem_m  [DEPTH];
  bit            pend_m [DEPTH];
  int            clr_left;
  int            clr_idx;

  regfile_sb #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .rd_ready1 (rd_ready1),
    .rd_ready2 (rd_ready2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      pend_m[i] = 1'b0;
    end
    clr_left = 0;
    clr_idx  = 0;
  endtask

  task automatic model_edge();
    if (clr_left > 0) begin
      mem_m[clr_idx]  = '0;
      pend_m[clr_idx] = 1'b0;
      clr_idx++;
      clr_left--;
    end else begin
      if (wr_en) begin
        mem_m[wr_addr]  = wr_data;
        pend_m[wr_addr] = 1'b0;
      end
      if (pend_set) pend_m[pend_addr] = 1'b1;
      if (clr_req) begin
        clr_left = DEPTH;
        clr_idx  = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic ps, input int pa, input logic cr);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
    pend_set  = ps;
    pend_addr = AW'(pa);
    clr_req   = cr;
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic check_ports(input string tag);
    logic [DW-1:0] e1, e2;
    logic          r1, r2, bm;
    bm = (clr_left > 0);
    e1 = mem_m[rd_addr1];
    e2 = mem_m[rd_addr2];
    r1 = !pend_m[rd_addr1] && !bm;
    r2 = !pend_m[rd_addr2] && !bm;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !bm && wr_addr == rd_addr1) begin e1 = wr_data; r1 = 1'b1; end
    if (wr_en && !bm && wr_addr == rd_addr2) begin e2 = wr_data; r2 = 1'b1; end
`endif
    chk({tag, ".data1"}, 32'(rd_data1), 32'(e1));
    chk({tag, ".data2"}, 32'(rd_data2), 32'(e2));
    chk({tag, ".ready1"}, 32'(rd_ready1), 32'(r1));
    chk({tag, ".ready2"}, 32'(rd_ready2), 32'(r2));
    chk({tag, ".busy"}, 32'(busy), 32'(bm));
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(i + 4);
      #1;
      check_ports(tag);
    end
  endtask

  initial begin
    int busy_cnt;
    model_reset();
    idle();
    rd_addr1 = '0;
    rd_addr2 = '0;
    reset_n  = 1'b0;
    #3;
    check_all("reset");
    #2;
    reset_n = 1'b1;
    tick();

    // Write r5 and observe the write-cycle and next-cycle read.
    drive(1'b1, 5, 16'hBEEF, 1'b0, 0, 1'b0);
    rd_addr1 = 3'd5;
    rd_addr2 = 3'd5;
    #1;
    check_ports("wr_cycle");
    tick();
    idle();
    #1;
    check_ports("wr_next");
    chk("r5_value", 32'(rd_data1), 32'h0000BEEF);

    // Scoreboard: set, clear by write, set wins over same-cycle write.
    drive(1'b0, 0, '0, 1'b1, 3, 1'b0);
    tick();
    idle();
    rd_addr2 = 3'd3;
    #1;
    check_ports("pend_set");
    chk("r3_pending", 32'(rd_ready2), 32'd0);
    drive(1'b1, 3, 16'h1234, 1'b0, 0, 1'b0);
    tick();
    idle();
    #1;
    check_ports("pend_clr");
    drive(1'b1, 3, 16'h1234, 1'b1, 3, 1'b0);
    tick();
    idle();
    #1;
    check_ports("pend_both");
    chk("r3_still_pend", 32'(rd_ready2), 32'd0);

    // Fill, sweep, and try a dropped write mid-sweep.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, DW'((i + 1) * 16'h1111), 1'b0, 0, 1'b0);
      tick();
    end
    idle();
    check_all("filled");
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1);
    tick();
    idle();
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) drive(1'b1, 2, 16'hAAAA, 1'b1, 6, 1'b1);
      rd_addr1 = AW'(c % DEPTH);
      rd_addr2 = 3'd2;
      #1;
      check_ports("sweep");
      if (busy) busy_cnt++;
      tick();
      idle();
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd8);
    check_all("after_sweep");

    // Asynchronous reset in the middle of a sweep.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, DW'(16'hA000 + i), 1'b1, i, 1'b0);
      tick();
    end
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 4; c++) tick();
    chk("mid_sweep_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_busy", 32'(busy), 32'd0);
    check_all("async_rst");
    #3;
    reset_n = 1'b1;
    tick();
    drive(1'b1, 4, 16'h4444, 1'b0, 0, 1'b0);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1);
    tick();
    idle();
    #1;
    check_ports("clr_again");
    chk("clr_accepted", 32'(busy), 32'd1);
    for (int c = 0; c < 10; c++) tick();
    check_all("clr_again_done");

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), DW'($urandom),
            1'($urandom_range(0, 3) == 0), int'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 24) == 0));
      rd_addr1 = AW'($urandom_range(0, DEPTH - 1));
      rd_addr2 = AW'($urandom_range(0, DEPTH - 1));
      #1;
      check_ports("rand");
      tick();
    end
    idle();
    #1;
    check_ports("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
